scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer_pkg.sv | 24 ++
 rtl/scan_sequencer_dwell_counter.sv | 38 +++
 rtl/scan_sequencer.sv | 167 ++++++++++++++++
 tb/tb_scan_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_sequencer_pkg.sv
// Shared types and constants for the 4:16 decoder scan sequencer.
// Holds the FSM state enum, index width/limits and an index step helper.
package scan_sequencer_pkg;

    localparam int IDX_W = 4;

    localparam logic [IDX_W-1:0] IDX_FIRST_UP = 4'd0;
    localparam logic [IDX_W-1:0] IDX_LAST_UP  = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Next index along the scan direction (down=1 counts towards 0).
    function automatic logic [IDX_W-1:0] idx_step(
        input logic [IDX_W-1:0] idx,
        input logic             down
    );
        return down ? (idx - 4'd1) : (idx + 4'd1);
    endfunction

endpackage

// File: rtl/scan_sequencer_dwell_counter.sv
// Dwell counter: counts 0..limit, flags terminal count, self-clears on tc.
// Ports: clk, rst (sync high), clr, en, limit[DWELL_W] in; tc out.
module dwell_counter #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [DWELL_W-1:0] limit,
    output logic               tc
);

    localparam logic [DWELL_W-1:0] ONE = 1;

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    assign tc = (cnt_q == limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : (cnt_q + ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Sweeps a 4-bit index over a 4:16 decoder, holding each index dwell+1 cycles.
// Ports: clk, rst (sync high), start, stop, continuous, dwell[DWELL_W] in;
//   idx_out[4], en_out, busy, done, wrap out.
// Optional macro SCAN_DOWN_EN adds input dir (1 = scan 15 down to 0).
module scan_sequencer
    import scan_sequencer_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
`ifdef SCAN_DOWN_EN
    input  logic               dir,
`endif
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell,
    output logic [IDX_W-1:0]   idx_out,
    output logic               en_out,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               en_q, en_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;

    logic               cnt_clr;
    logic               cnt_en;
    logic               cnt_tc;

    logic               down;
    logic [IDX_W-1:0]   first_start;
    logic [IDX_W-1:0]   idx_first;
    logic [IDX_W-1:0]   idx_last;

`ifdef SCAN_DOWN_EN
    logic dir_q, dir_d;

    // The first index at start comes from the live dir input, since the
    // latched copy only becomes valid on the same edge.
    assign first_start = dir ? IDX_LAST_UP : IDX_FIRST_UP;
    assign down        = dir_q;
`else
    assign first_start = IDX_FIRST_UP;
    assign down        = 1'b0;
`endif

    assign idx_first = down ? IDX_LAST_UP  : IDX_FIRST_UP;
    assign idx_last  = down ? IDX_FIRST_UP : IDX_LAST_UP;

    dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (dwell_q),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        en_d    = en_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        dwell_d = dwell_q;
        cont_d  = cont_q;
`ifdef SCAN_DOWN_EN
        dir_d   = dir_q;
`endif
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                en_d    = 1'b0;
                cnt_clr = 1'b1;
                if (start && !stop) begin
                    state_d = SCAN;
                    idx_d   = first_start;
                    en_d    = 1'b1;
                    dwell_d = dwell;
                    cont_d  = continuous;
`ifdef SCAN_DOWN_EN
                    dir_d   = dir;
`endif
                end
            end
            SCAN: begin
                if (stop) begin
                    // Abort wins over any advance due this cycle.
                    state_d = IDLE;
                    en_d    = 1'b0;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        if (idx_q == idx_last) begin
                            if (cont_q) begin
                                idx_d  = idx_first;
                                wrap_d = 1'b1;
                            end else begin
                                state_d = DONE;
                                en_d    = 1'b0;
                                done_d  = 1'b1;
                            end
                        end else begin
                            idx_d = idx_step(idx_q, down);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                en_d    = 1'b0;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
`ifdef SCAN_DOWN_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
`ifdef SCAN_DOWN_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign idx_out = idx_q;
    assign en_out  = en_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer driving a 4:16 decoder model.
// Cycle k=1 is the first sample after the edge that accepts start.
module tb_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic [7:0]  dwell = 8'd0;
`ifdef SCAN_DOWN_EN
    logic        dir = 1'b0;
`endif
    logic [3:0]  idx_out;
    logic        en_out;
    logic        busy;
    logic        done;
    logic        wrap;
    logic [15:0] dec;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    scan_sequencer #(
        .DWELL_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
`ifdef SCAN_DOWN_EN
        .dir        (dir),
`endif
        .continuous (continuous),
        .dwell      (dwell),
        .idx_out    (idx_out),
        .en_out     (en_out),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap)
    );

    // 4:16 decoder: select from idx_out, enable from en_out.
    assign dec = en_out ? (16'd1 << idx_out) : 16'd0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [7:0] dw, input logic cont);
        start      = 1'b1;
        dwell      = dw;
        continuous = cont;
        step();
        start      = 1'b0;
    endtask

    initial begin
        int busy_n;
        int done_k;
        int n_done;

        // Reset state
        step();
        step();
        chk("rst_idx", idx_out, 0);
        chk("rst_en", en_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);
        rst = 1'b0;
        step();

        // Single sweep, dwell 0
        kick(8'd0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            chk("s0_idx", idx_out, k - 1);
            chk("s0_en", en_out, 1);
            chk("s0_dec", dec, 32'd1 << (k - 1));
            chk("s0_done", done, 0);
            step();
        end
        chk("s0_done_pulse", done, 1);
        chk("s0_en_off", en_out, 0);
        chk("s0_busy_done", busy, 1);
        chk("s0_dec_off", dec, 0);
        step();
        chk("s0_idle_busy", busy, 0);
        chk("s0_idle_done", done, 0);
        step();

        // Single sweep, dwell 2; dwell input changed mid-sweep
        kick(8'd2, 1'b0);
        dwell  = 8'd5;
        busy_n = 0;
        done_k = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k <= 48) chk("d2_idx", idx_out, (k - 1) / 3);
            if (busy) busy_n++;
            if (done && done_k == 0) done_k = k;
            step();
        end
        chk("d2_done_at", done_k, 49);
        chk("d2_busy_len", busy_n, 49);

        // Continuous, dwell 0, 40 cycles; continuous input dropped mid-run
        kick(8'd0, 1'b1);
        continuous = 1'b0;
        n_done = 0;
        for (int k = 1; k <= 40; k++) begin
            chk("c_idx", idx_out, (k - 1) % 16);
            chk("c_wrap", wrap, (k == 17 || k == 33) ? 1 : 0);
            chk("c_en", en_out, 1);
            if (done) n_done++;
            step();
        end
        chk("c_no_done", n_done, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("c_stop_en", en_out, 0);
        chk("c_stop_busy", busy, 0);
        chk("c_stop_wrap", wrap, 0);
        chk("c_stop_done", done, 0);
        step();

        // Stop at index 7, then start+stop together in IDLE
        kick(8'd0, 1'b0);
        for (int k = 1; k < 8; k++) step();
        chk("st_idx7", idx_out, 7);
        stop = 1'b1;
        step();
        chk("st_en", en_out, 0);
        chk("st_busy", busy, 0);
        chk("st_dec", dec, 0);
        chk("st_done", done, 0);
        start = 1'b1;
        step();
        chk("ss_busy", busy, 0);
        chk("ss_en", en_out, 0);
        step();
        chk("ss_busy2", busy, 0);
        start = 1'b0;
        stop  = 1'b0;
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            if (done || busy) n_done++;
            step();
        end
        chk("st_quiet", n_done, 0);

        // Reset mid-sweep at index 9
        kick(8'd3, 1'b1);
        for (int k = 1; k < 37; k++) step();
        chk("r_idx9", idx_out, 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("r_idx", idx_out, 0);
        chk("r_en", en_out, 0);
        chk("r_busy", busy, 0);
        chk("r_done", done, 0);
        chk("r_wrap", wrap, 0);
        step();
        chk("r_stay_idle", busy, 0);

        // start pulsed during SCAN is ignored
        kick(8'd0, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            if (k <= 16) begin
                chk("sp_idx", idx_out, k - 1);
                chk("sp_en", en_out, 1);
            end else begin
                chk("sp_done", done, 1);
            end
            start = (k == 5);
            step();
        end
        start = 1'b0;
        chk("sp_idle", busy, 0);
        step();

`ifdef SCAN_DOWN_EN
        // Downward single sweep
        dir = 1'b1;
        kick(8'd0, 1'b0);
        dir = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk("dn_idx", idx_out, 16 - k);
            chk("dn_en", en_out, 1);
            step();
        end
        chk("dn_done", done, 1);
        step();
        step();

        // Downward continuous wraps 0 -> 15
        dir = 1'b1;
        kick(8'd0, 1'b1);
        dir = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            chk("dnc_wrap", wrap, (k == 17) ? 1 : 0);
            if (k == 17) chk("dnc_idx", idx_out, 15);
            if (k < 17) step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("dnc_stop", busy, 0);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
